// File: rtl/vx_mem_rsp_pkg.sv
// Shared types and default widths for the Vortex memory responder.
// Widths are the standard Vortex memory interface values.
package vx_mem_rsp_pkg;

  localparam int MEM_DATA_WIDTH = 512;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_TAG_WIDTH  = 8;

  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]  tag;
  } mem_rsp_t;

endpackage

// File: rtl/vx_rsp_fifo.sv
// First-word-fall-through response FIFO; the head entry is visible while not empty.
// Output reads as zero when empty so the response bus is quiet after reset.
module vx_rsp_fifo
  import vx_mem_rsp_pkg::*;
#(
  parameter type T     = mem_rsp_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/vx_mem_responder.sv
// Responder end of the Vortex memory interface: line-wide RAM with byte-enabled writes,
// fixed-latency read pipeline and a credited fall-through response FIFO.
module vx_mem_responder
  import vx_mem_rsp_pkg::*;
#(
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int BYTEEN_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH      = MEM_TAG_WIDTH,
  parameter int DEPTH_LOG2     = 10,
  parameter int RSP_LATENCY    = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  localparam int CW   = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam int NSTG = RSP_LATENCY - 1;

  logic [CW-1:0]         credits;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req_acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rsp_pop;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  rsp_t                  rd_rsp;
  rsp_t                  fifo_din;
  rsp_t                  fifo_dout;
  logic                  unused_ok;

  logic [DATA_WIDTH-1:0] ram [2**DEPTH_LOG2];

  assign idx           = mem_req_addr[DEPTH_LOG2-1:0];
  assign mem_req_ready = (credits != '0);
  assign req_acc       = mem_req_valid && mem_req_ready;
  assign rd_acc        = req_acc && !mem_req_rw;
  assign wr_acc        = req_acc && mem_req_rw;
  assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;
  assign unused_ok     = ^{mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2], fifo_full};

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTEEN_WIDTH; i++) begin
      if (wr_acc && mem_req_byteen[i]) ram[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
    end
  end

  // RAM read happens in the accept cycle, so a write on the previous edge is already visible
  always_comb begin
    rd_rsp      = '0;
    rd_rsp.data = ram[idx];
    rd_rsp.tag  = mem_req_tag;
  end

  // The FIFO write is the last latency stage; NSTG registers sit in front of it
  if (NSTG == 0) begin : g_direct
    assign fifo_push = rd_acc;
    assign fifo_din  = rd_rsp;
  end else begin : g_pipe
    rsp_t            rsp_p [NSTG];
    logic [NSTG-1:0] vld_p;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= rd_acc;
        for (int i = 1; i < NSTG; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      rsp_p[0] <= rd_rsp;
      for (int i = 1; i < NSTG; i++) rsp_p[i] <= rsp_p[i-1];
    end

    assign fifo_push = vld_p[NSTG-1];
    assign fifo_din  = rsp_p[NSTG-1];
  end

  vx_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (rsp_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem_rsp_valid = !fifo_empty;
  assign mem_rsp_data  = fifo_dout.data;
  assign mem_rsp_tag   = fifo_dout.tag;

  // Credits count free slots across pipeline plus FIFO, so the FIFO cannot overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits  <= CW'(RSP_FIFO_DEPTH);
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      credits <= credits - CW'(rd_acc) + CW'(rsp_pop);
      if (rd_acc) rd_count <= rd_count + 32'd1;
      if (wr_acc) wr_count <= wr_count + 32'd1;
    end
  end

  a_credit_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rd_acc && !rsp_pop && credits == '0));
  a_credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_pop && !rd_acc && credits == CW'(RSP_FIFO_DEPTH)));

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: vector table for write/read traffic plus
// hand-written sequences for backpressure, same-cycle credit return and mid-flight reset.
module tb_vx_mem_responder;

  localparam int DW  = 512;
  localparam int BW  = 64;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_rw = 1'b0;
  logic [BW-1:0] mem_req_byteen = '0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b1;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;

  int n_vec = 0;
  int n_err = 0;

  vx_mem_responder #(
    .DATA_WIDTH     (DW),
    .BYTEEN_WIDTH   (BW),
    .ADDR_WIDTH     (AW),
    .TAG_WIDTH      (TW),
    .DEPTH_LOG2     (10),
    .RSP_LATENCY    (LAT),
    .RSP_FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [9];
  logic [DW-1:0] pat1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic rw, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [TW-1:0] tag, input logic [DW-1:0] exp);
    vecs[i].rw   = rw;
    vecs[i].be   = be;
    vecs[i].addr = addr;
    vecs[i].data = data;
    vecs[i].tag  = tag;
    vecs[i].exp  = exp;
  endtask

  // Present one request and hold it until accepted; returns at accept edge + 1
  task automatic do_req(input logic rw, input logic [BW-1:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [TW-1:0] tag);
    int cnt;
    mem_req_rw     = rw;
    mem_req_byteen = be;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_tag    = tag;
    mem_req_valid  = 1'b1;
    cnt = 0;
    while (!mem_req_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 50) chk("req_ready_timeout", DW'(mem_req_ready), DW'(1));
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [DW-1:0] exp, input string name);
    int lat;
    do_req(1'b0, '0, addr, '0, tag);
    lat = 0;
    while (!mem_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, DW'(lat), DW'(LAT - 1));
    chk({name, "_tag"}, DW'(mem_rsp_tag), DW'(tag));
    chk({name, "_data"}, mem_rsp_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int            next;
    int            got;
    logic          acc;
    logic          pop;
    logic [TW-1:0] ptag;
    logic          seen;

    for (int i = 0; i < 16; i++) begin
      if (i == 0)       pat1[i*32 +: 32] = 32'h12345678;
      else if (i == 15) pat1[i*32 +: 32] = 32'h11111111;
      else              pat1[i*32 +: 32] = {16'hA5A5, 16'(i)};
    end

    set_vec(0, 1'b1, '1,                     26'h400A, pat1,            8'h00, '0);
    set_vec(1, 1'b0, '0,                     26'h400A, '0,              8'h5A, pat1);
    set_vec(2, 1'b1, '1,                     26'h0010, '0,              8'h00, '0);
    set_vec(3, 1'b1, 64'h000F,               26'h0010, {64{8'hFF}},     8'h00, '0);
    set_vec(4, 1'b0, '0,                     26'h0010, '0,              8'h21, {480'd0, 32'hFFFFFFFF});
    set_vec(5, 1'b0, '0,                     26'h440A, '0,              8'h33, pat1);
    set_vec(6, 1'b1, '1,                     26'h0020, {64{8'h5A}},     8'h00, '0);
    set_vec(7, 1'b1, 64'h8000000000000001,   26'h0020, {64{8'hCC}},     8'h00, '0);
    set_vec(8, 1'b0, '0,                     26'h0020, '0,              8'h77, {8'hCC, {62{8'h5A}}, 8'hCC});

    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_req_ready", DW'(mem_req_ready), DW'(1));
    chk("rst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
    chk("rst_rsp_data", mem_rsp_data, '0);
    chk("rst_rsp_tag", DW'(mem_rsp_tag), DW'(0));
    chk("rst_counts", DW'({rd_count, wr_count}), DW'(0));

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rw) do_req(1'b1, vecs[i].be, vecs[i].addr, vecs[i].data, 8'h00);
      else            do_read(vecs[i].addr, vecs[i].tag, vecs[i].exp, $sformatf("vec%0d", i));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("no_write_rsp", DW'(mem_rsp_valid), DW'(0));
    chk("rd_count_table", DW'(rd_count), DW'(4));
    chk("wr_count_table", DW'(wr_count), DW'(5));

    // Backpressure: six back-to-back reads against a stalled response port
    mem_rsp_ready = 1'b0;
    next = 1;
    mem_req_rw = 1'b0;
    mem_req_addr = 26'h0010;
    mem_req_tag = 8'd1;
    mem_req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      acc = mem_req_valid && mem_req_ready;
      @(posedge clk); #1;
      if (acc) begin
        next++;
        mem_req_tag = TW'(next);
      end
    end
    chk("bp_accepted", DW'(next - 1), DW'(4));
    chk("bp_req_ready", DW'(mem_req_ready), DW'(0));
    chk("bp_head_tag", DW'(mem_rsp_tag), DW'(1));
    repeat (2) @(posedge clk);
    #1;
    chk("bp_head_hold", DW'(mem_rsp_tag), DW'(1));
    mem_rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      acc  = mem_req_valid && mem_req_ready;
      pop  = mem_rsp_valid;
      ptag = mem_rsp_tag;
      @(posedge clk); #1;
      if (acc) begin
        next++;
        if (next > 6) mem_req_valid = 1'b0;
        else          mem_req_tag = TW'(next);
      end
      if (pop) begin
        chk($sformatf("bp_order%0d", got), DW'(ptag), DW'(got + 1));
        got++;
      end
    end
    mem_req_valid = 1'b0;
    chk("bp_rsp_count", DW'(got), DW'(6));
    chk("bp_rd_count", DW'(rd_count), DW'(10));

    // Credits at 1: a read accept and a response pop on the same edge
    mem_rsp_ready = 1'b0;
    do_req(1'b0, '0, 26'h400A, '0, 8'h41);
    do_req(1'b0, '0, 26'h400A, '0, 8'h42);
    do_req(1'b0, '0, 26'h400A, '0, 8'h43);
    repeat (3) @(posedge clk);
    #1;
    chk("c1_ready_before", DW'(mem_req_ready), DW'(1));
    mem_req_tag   = 8'h44;
    mem_req_valid = 1'b1;
    mem_rsp_ready = 1'b1;
    ptag = mem_rsp_tag;
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    chk("c1_ready_after", DW'(mem_req_ready), DW'(1));
    chk("c1_pop_tag", DW'(ptag), DW'(8'h41));
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      pop  = mem_rsp_valid;
      ptag = mem_rsp_tag;
      if (pop && got == 2) chk("c1_last_data", mem_rsp_data, pat1);
      @(posedge clk); #1;
      if (pop) begin
        chk($sformatf("c1_order%0d", got), DW'(ptag), DW'(8'h42 + got));
        got++;
      end
    end
    chk("c1_rsp_count", DW'(got), DW'(3));

    // Reset with three reads in flight
    mem_rsp_ready = 1'b0;
    do_req(1'b0, '0, 26'h0010, '0, 8'h91);
    do_req(1'b0, '0, 26'h0010, '0, 8'h92);
    do_req(1'b0, '0, 26'h0010, '0, 8'h93);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_rsp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (mem_rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mr_no_rsp", DW'(seen), DW'(0));
    chk("mr_ready", DW'(mem_req_ready), DW'(1));
    chk("mr_counts", DW'({rd_count, wr_count}), DW'(0));
    do_read(26'h400A, 8'h66, pat1, "mr_ram_kept");
    chk("mr_rd_count", DW'(rd_count), DW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
